regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each register.
REQ-002 SHALL have parameter DEPTH, default 32: number of registers, power of two, 2..256.
REQ-003 SHALL have parameter AW, default 5: address width, equal to log2(DEPTH).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port rw  input  1: write enable; 1 writes data3 to addr3.
REQ-007 SHALL have port addr1  input  AW: read port 1 address.
REQ-008 SHALL have port addr2  input  AW: read port 2 address.
REQ-009 SHALL have port out1  output  WIDTH: read port 1 data.
REQ-010 SHALL have port out2  output  WIDTH: read port 2 data.
REQ-011 SHALL have port addr3  input  AW: write address.
REQ-012 SHALL have port data3  input  WIDTH: write data.
REQ-013 SHALL have port clr  input  1: request to clear the whole file.
REQ-014 SHALL have port busy  output  1: clear sequence in progress.
REQ-015 SHALL have port wr_drop  output  1: registered one-cycle pulse, a requested write was discarded.

Function
REQ-016 SHALL use FSM states IDLE and CLEAR, with a clear counter cnt of AW bits.
REQ-017 In CLEAR, each cycle SHALL write 0 to entry cnt and increment cnt.
REQ-018 CLEAR SHALL return to IDLE after writing entry DEPTH-1; busy SHALL drop on the following cycle.
REQ-019 A full clear SHALL take exactly DEPTH cycles with busy=1.
REQ-020 IDLE with clr=1 SHALL enter CLEAR with cnt=0 on the next edge; clr while in CLEAR SHALL be ignored and SHALL NOT restart the sequence.
REQ-021 Writes SHALL occur on the rising edge when rw=1, busy=0 and clr=0.
REQ-022 rw=1 while busy=1, or in the same cycle as an accepted clr, SHALL drop the write and assert wr_drop on the next cycle.
REQ-023 Reads SHALL be combinational from addr1 and addr2, with zero latency.
REQ-024 Bypass: when a write is accepted this cycle and addrN==addr3, outN SHALL equal data3.
REQ-025 While busy=1, out1 and out2 SHALL read 0 regardless of address.
REQ-026 cnt wrap from DEPTH-1 to 0 SHALL coincide with the CLEAR->IDLE transition.

Reset
REQ-027 reset=1 SHALL force state CLEAR, cnt=0, busy=1 and wr_drop=0 on the next edge; reset overrides clr and rw.
REQ-028 After reset deasserts, the file SHALL be all-zero once busy falls (DEPTH cycles).
REQ-029 reset asserted mid-CLEAR SHALL restart the clear at cnt=0.

Configuration
REQ-030 Macro REGFILE_ZERO_REG_EN defined: entry 0 SHALL read as 0 on both ports, writes to addr3=0 SHALL be discarded without a wr_drop pulse, and the REQ-024 bypass SHALL NOT apply at address 0.
REQ-031 Macro REGFILE_ZERO_REG_EN undefined: entry 0 SHALL behave as an ordinary register.

Verification
REQ-032 Reset pulse, then 32 idle cycles -> busy=1 for exactly 32 cycles; every address then reads 0.
REQ-033 After clear, write 0x0000_00A5 to addr 7, then read addr1=7 and addr2=7 -> both ports read 0x0000_00A5; the same-cycle bypass also returns 0x0000_00A5.
REQ-034 clr=1 and rw=1 (addr 3, 0x1234) in the same cycle -> write dropped, wr_drop=1 for one cycle, addr 3 reads 0 after busy falls.
REQ-035 reset asserted at clear cycle 10 -> cnt restarts at 0 and busy stays high for 32 more cycles.
REQ-036 With REGFILE_ZERO_REG_EN: write 0xFFFF_FFFF to addr 0 -> reads 0 and wr_drop=0; without the macro -> reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: two-read/one-write register file with a sequenced whole-file clear.
// Build option: define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_param #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rw,
    input  logic [AW-1:0]    addr1,
    input  logic [AW-1:0]    addr2,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    input  logic [AW-1:0]    addr3,
    input  logic [WIDTH-1:0] data3,
    input  logic             clr,
    output logic             busy,
    output logic             wr_drop
);
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0]    ZERO_ADDR = {AW{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_DATA = {WIDTH{1'b0}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_wr_drop;
    logic             w_busy;
    logic             w_clr_acc;
    logic             w_wr_req;
    logic             w_wr_acc;

    // A clear request is only honoured from IDLE; reset takes priority over everything.
    assign w_clr_acc = (r_state == S_IDLE) && clr && !reset;
    assign w_wr_req  = rw && !reset && !w_busy && !clr;
`ifdef REGFILE_ZERO_REG_EN
    assign w_wr_acc  = w_wr_req && (addr3 != ZERO_ADDR);
`else
    assign w_wr_acc  = w_wr_req;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (reset) begin
            w_state_nxt = S_CLEAR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr) begin
                        w_state_nxt = S_CLEAR;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == LAST_ADDR) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_CLEAR;
                    end
                end
                default: w_state_nxt = S_CLEAR;
            endcase
        end
    end

    // State-decoded outputs; an illegal state reports busy
    always_comb begin
        w_busy = 1'b1;
        case (r_state)
            S_IDLE:  w_busy = 1'b0;
            S_CLEAR: w_busy = 1'b1;
            default: w_busy = 1'b1;
        endcase
    end

    assign busy    = w_busy;
    assign wr_drop = r_wr_drop;

    // Clear counter: natural AW-bit wrap lines up with leaving CLEAR
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= ZERO_ADDR;
        end else if (r_state == S_CLEAR) begin
            r_cnt <= r_cnt + AW'(1);
        end else begin
            r_cnt <= ZERO_ADDR;
        end
    end

    // Write-drop pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= rw && (w_busy || w_clr_acc);
        end
    end

    // Storage array: clear sweep has priority over user writes
    always_ff @(posedge clk) begin
        if (!reset && (r_state == S_CLEAR)) begin
            r_mem[r_cnt] <= ZERO_DATA;
        end else if (w_wr_acc) begin
            r_mem[addr3] <= data3;
        end
    end

    // Zero-latency read ports with write-through bypass
    always_comb begin
        out1 = ZERO_DATA;
        out2 = ZERO_DATA;
        if (w_busy) begin
            out1 = ZERO_DATA;
        end
`ifdef REGFILE_ZERO_REG_EN
        else if (addr1 == ZERO_ADDR) begin
            out1 = ZERO_DATA;
        end
`endif
        else if (w_wr_acc && (addr1 == addr3)) begin
            out1 = data3;
        end else begin
            out1 = r_mem[addr1];
        end
        if (w_busy) begin
            out2 = ZERO_DATA;
        end
`ifdef REGFILE_ZERO_REG_EN
        else if (addr2 == ZERO_ADDR) begin
            out2 = ZERO_DATA;
        end
`endif
        else if (w_wr_acc && (addr2 == addr3)) begin
            out2 = data3;
        end else begin
            out2 = r_mem[addr2];
        end
    end
endmodule

// File: tb/tb_regfile_param.sv
// Directed, table-driven bench for regfile_param (default 32x32 configuration).
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        reset, rw, clr;
    logic [4:0]  addr1, addr2, addr3;
    logic [31:0] data3, out1, out2;
    logic        busy, wr_drop;

    int vec_cnt  = 0;
    int fail_cnt = 0;
    int busy_cnt;

    typedef struct {
        logic        rw;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic [31:0] d;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;
    vec_t tbl [10];

    regfile_param #(.WIDTH(32), .DEPTH(32), .AW(5)) dut (
        .clk(clk), .reset(reset), .rw(rw), .addr1(addr1), .addr2(addr2),
        .out1(out1), .out2(out2), .addr3(addr3), .data3(data3), .clr(clr),
        .busy(busy), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        rw = 1'b0; clr = 1'b0; addr3 = 5'd0; data3 = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 5'd7,  5'd7,  5'd7,  32'h0000_00A5, 32'h0000_00A5, 32'h0000_00A5};
        tbl[1] = '{1'b0, 5'd7,  5'd3,  5'd0,  32'h0000_0000, 32'h0000_00A5, 32'h0000_0000};
        tbl[2] = '{1'b1, 5'd3,  5'd7,  5'd3,  32'h0000_4321, 32'h0000_4321, 32'h0000_00A5};
        tbl[3] = '{1'b1, 5'd10, 5'd3,  5'd10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_4321};
        tbl[4] = '{1'b0, 5'd10, 5'd0,  5'd0,  32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[5] = '{1'b1, 5'd7,  5'd7,  5'd7,  32'h0000_005A, 32'h0000_005A, 32'h0000_005A};
        tbl[6] = '{1'b0, 5'd7,  5'd10, 5'd0,  32'h0000_0000, 32'h0000_005A, 32'hDEAD_BEEF};
        tbl[7] = '{1'b1, 5'd31, 5'd30, 5'd31, 32'h8000_0001, 32'h8000_0001, 32'h0000_0000};
        tbl[8] = '{1'b0, 5'd31, 5'd31, 5'd0,  32'h0000_0000, 32'h8000_0001, 32'h8000_0001};
        tbl[9] = '{1'b1, 5'd21, 5'd20, 5'd20, 32'h0000_0011, 32'h0000_0000, 32'h0000_0011};

        // Reset pulse, then count the clear sweep
        idle_in(); addr1 = 5'd0; addr2 = 5'd0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_wr_drop", 32'(wr_drop), 32'd0);
        chk("reset_out1", out1, 32'd0);
        busy_cnt = 1;
        for (int n = 1; n < 100; n++) begin
            @(negedge clk); #1;
            if (!busy) break;
            busy_cnt++;
        end
        chk("reset_clear_len", 32'(busy_cnt), 32'd32);
        for (int i = 0; i < 32; i++) begin
            addr1 = 5'(i); addr2 = 5'(31 - i); #1;
            chk("post_reset_out1", out1, 32'd0);
            chk("post_reset_out2", out2, 32'd0);
        end

        // Table: writes, reads and same-cycle bypass in IDLE
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            rw = tbl[v].rw; addr1 = tbl[v].a1; addr2 = tbl[v].a2;
            addr3 = tbl[v].a3; data3 = tbl[v].d; clr = 1'b0;
            #1;
            chk("tbl_out1", out1, tbl[v].e1);
            chk("tbl_out2", out2, tbl[v].e2);
            chk("tbl_busy", 32'(busy), 32'd0);
            chk("tbl_wr_drop", 32'(wr_drop), 32'd0);
        end

        // clr and rw together: write dropped, no bypass; then clr/rw during the sweep
        @(negedge clk);
        clr = 1'b1; rw = 1'b1; addr3 = 5'd3; data3 = 32'h0000_1234; addr1 = 5'd3; addr2 = 5'd7;
        #1;
        chk("clr_rw_no_bypass", out1, 32'h0000_4321);
        chk("clr_rw_busy_low", 32'(busy), 32'd0);
        @(negedge clk);
        idle_in();
        #1;
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_wr_drop", 32'(wr_drop), 32'd1);
        chk("busy_reads_zero", out2, 32'd0);
        busy_cnt = 1;
        for (int n = 1; n < 100; n++) begin
            @(negedge clk);
            clr   = (n == 5);
            rw    = (n == 8);
            data3 = 32'hFFFF_FFFF;
            #1;
            if (n == 1) chk("wr_drop_one_cycle", 32'(wr_drop), 32'd0);
            if (n == 9) chk("busy_rw_wr_drop", 32'(wr_drop), 32'd1);
            if (!busy) break;
            busy_cnt++;
        end
        idle_in();
        chk("clr_len_ignores_clr", 32'(busy_cnt), 32'd32);
        addr1 = 5'd3; addr2 = 5'd20; #1;
        chk("clr_addr3_zero", out1, 32'd0);
        chk("clr_addr20_zero", out2, 32'd0);

        // Reset at clear cycle 10 restarts the sweep
        @(negedge clk);
        rw = 1'b1; addr3 = 5'd12; data3 = 32'h0000_CAFE; addr1 = 5'd12;
        @(negedge clk);
        idle_in(); #1;
        chk("pre_clear_write", out1, 32'h0000_CAFE);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 10; k++) @(negedge clk);
        #1;
        chk("mid_clear_busy", 32'(busy), 32'd1);
        reset = 1'b1; rw = 1'b1; clr = 1'b1;
        @(negedge clk);
        reset = 1'b0; idle_in(); #1;
        chk("mid_reset_wr_drop", 32'(wr_drop), 32'd0);
        busy_cnt = busy ? 1 : 0;
        for (int n = 1; n < 100; n++) begin
            @(negedge clk); #1;
            if (!busy) break;
            busy_cnt++;
        end
        chk("mid_reset_clear_len", 32'(busy_cnt), 32'd32);
        addr1 = 5'd12; #1;
        chk("mid_reset_addr12", out1, 32'd0);

        // Entry 0 behaviour
        @(negedge clk);
        rw = 1'b1; addr3 = 5'd0; data3 = 32'hFFFF_FFFF; addr1 = 5'd0; addr2 = 5'd0;
        #1;
`ifdef REGFILE_ZERO_REG_EN
        chk("zero_bypass", out2, 32'd0);
`else
        chk("zero_bypass", out2, 32'hFFFF_FFFF);
`endif
        @(negedge clk);
        idle_in(); #1;
`ifdef REGFILE_ZERO_REG_EN
        chk("zero_read", out1, 32'd0);
`else
        chk("zero_read", out1, 32'hFFFF_FFFF);
`endif
        chk("zero_wr_drop", 32'(wr_drop), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end
endmodule
